sha256_compress: RTL

Iterative SHA-256 compression engine for the miner datapath. It replaces the stand-alone bitwise helper functions (majority, choose, Σ/σ) with one sequential block. The block accepts a 256-bit chaining state and a 512-bit message block, then runs the 64 SHA-256 rounds at a configurable number of rounds per clock. It returns the 256-bit updated chaining value over a valid/ready handshake. Nonce-search control instantiates one or more of these, chaining two compressions per double-SHA.

---
 rtl/sha256_compress.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/sha256_compress.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sha256_compress
//  Description : Iterative SHA-256 compression engine. Accepts a 256-bit
//                chaining value and a 512-bit padded block, runs the 64
//                rounds at ROUNDS_PER_CYCLE rounds per clock, and returns the
//                updated chaining value over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sha256_compress #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] state_in,
    input  logic [511:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out,
    output logic         busy
);

    localparam int c_rounds = ROUNDS_PER_CYCLE;

    // Only power-of-two unroll factors that divide 64 evenly are supported,
    // so the final group of rounds always ends exactly on round 63.
    generate
        if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
              ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rounds
            $error("sha256_compress: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    // Round constants K[0..63]
    localparam logic [31:0] c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word 0 of every packed array is the most significant word, so a..h,
    // H0..H7 and W0..W15 line up directly with the big-endian port layout.
    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_busy;
    logic [255:0]        r_digest;
    logic [5:0]          r_t;
    logic [0:7][31:0]    r_h;
    logic [0:7][31:0]    r_v;
    logic [0:15][31:0]   r_w;

    logic [0:7][31:0]    w_v_next;
    logic [0:15][31:0]   w_w_next;
    logic [0:7][31:0]    w_sum;
    logic                w_last;

    assign w_last = (({1'b0, r_t} + 7'(c_rounds)) == 7'd64);

    // One cycle of R chained rounds plus the matching schedule-window advance
    always_comb begin
        logic [31:0] ext [0:15+c_rounds];
        logic [31:0] v   [0:7];
        logic [31:0] t1;
        logic [31:0] t2;
        logic [5:0]  idx;
        t1  = '0;
        t2  = '0;
        idx = '0;
        // The window holds W[t..t+15]; extend it by R freshly scheduled words.
        // New words may depend on earlier new words, hence the chained loop.
        for (int k = 0; k < 16; k++) begin
            ext[k] = r_w[k];
        end
        for (int j = 0; j < c_rounds; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j]
                      + small_sigma0(ext[1+j]) + ext[j];
        end
        for (int k = 0; k < 8; k++) begin
            v[k] = r_v[k];
        end
        for (int i = 0; i < c_rounds; i++) begin
            idx  = r_t + 6'(i);
            t1   = v[7] + big_sigma1(v[4]) + ch(v[4], v[5], v[6]) + c_k[idx] + ext[i];
            t2   = big_sigma0(v[0]) + maj(v[0], v[1], v[2]);
            v[7] = v[6];
            v[6] = v[5];
            v[5] = v[4];
            v[4] = v[3] + t1;
            v[3] = v[2];
            v[2] = v[1];
            v[1] = v[0];
            v[0] = t1 + t2;
        end
        for (int k = 0; k < 8; k++) begin
            w_v_next[k] = v[k];
            w_sum[k]    = r_h[k] + v[k];
        end
        for (int k = 0; k < 16; k++) begin
            w_w_next[k] = ext[k+c_rounds];
        end
    end

    // Control FSM and datapath registers; handshake outputs are registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_digest    <= '0;
            r_t         <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_w         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_h        <= state_in;
                        r_v        <= state_in;
                        r_w        <= block_in;
                        r_t        <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_v <= w_v_next;
                    r_w <= w_w_next;
                    r_t <= r_t + 6'(c_rounds);
                    if (w_last) begin
                        r_digest    <= w_sum;
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign digest_out = r_digest;

endmodule
`default_nettype wire
